// File: rtl/clk_div_bank.sv
// Bank of NCH independent programmable square-wave generators clocked from CK.
// Each channel toggles CKO after half+1 enabled cycles and strobes TICK on every rising edge of CKO.
module clk_div_bank #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned NCH          = 4,
    parameter int unsigned SELW         = 2,
    parameter int unsigned DEFAULT_HALF = 49999
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             WE,
    input  logic [SELW-1:0]  SEL,
    input  logic [WIDTH-1:0] HALF,
    input  logic             ALIGN,
    input  logic [NCH-1:0]   EN,
    output logic [NCH-1:0]   CKO,
    output logic [NCH-1:0]   TICK
);

    logic [NCH-1:0][WIDTH-1:0] half_q, half_d;
    logic [NCH-1:0][WIDTH-1:0] ct_q, ct_d;
    logic [NCH-1:0]            cko_q, cko_d;
    logic [NCH-1:0]            tick_q, tick_d;
    logic [NCH-1:0]            wsel;

    // One-hot write select; an out-of-range SEL matches no channel.
    always_comb begin
        wsel = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            wsel[i] = WE && (32'(SEL) == i);
        end
    end

    always_comb begin
        half_d = half_q;
        ct_d   = ct_q;
        cko_d  = cko_q;
        tick_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (wsel[i]) begin
                half_d[i] = HALF;
            end
            if (ALIGN || wsel[i]) begin
                ct_d[i]  = '0;
                cko_d[i] = 1'b0;
            end else if (EN[i]) begin
                if (ct_q[i] < half_q[i]) begin
                    ct_d[i] = ct_q[i] + 1'b1;
                end else begin
                    ct_d[i]   = '0;
                    cko_d[i]  = ~cko_q[i];
                    tick_d[i] = ~cko_q[i];
                end
            end
        end
    end

    always_ff @(posedge CK) begin
        if (!RST) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                half_q[i] <= WIDTH'(DEFAULT_HALF);
            end
            ct_q   <= '0;
            cko_q  <= '0;
            tick_q <= '0;
        end else begin
            half_q <= half_d;
            ct_q   <= ct_d;
            cko_q  <= cko_d;
            tick_q <= tick_d;
        end
    end

    assign CKO  = cko_q;
    assign TICK = tick_q;

endmodule
